// File: rtl/spi_pkg.sv
// Shared types and default command codes for the SPI command controller.
package spi_pkg;

    localparam logic [7:0] DEF_CMD_READ  = 8'h03;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Frames the MOSI bit stream into bytes, MSB first; a partial byte is
// thrown away whenever chip select goes high.
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       bit_valid,
    input  logic       mosi,
    output logic [7:0] rx_byte,
    output logic       byte_done
);

    // Only the seven most recent bits need storing: the eighth is the live mosi bit.
    logic [6:0] rx;
    logic [2:0] bit_cnt;

    // Shift in accepted bits; chip select high clears the partial byte and drops any coincident bit.
    always_ff @(posedge clk) begin
        if (rst || cs_n) begin
            rx      <= '0;
            bit_cnt <= '0;
        end else if (bit_valid) begin
            rx      <= {rx[5:0], mosi};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign rx_byte   = {rx, mosi};
    assign byte_done = bit_valid && !cs_n && (bit_cnt == 3'd7);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: command byte, address byte, then a burst of write
// data or serialised read data against a single-port memory interface.
module spi_cmd_ctrl
    import spi_pkg::*;
#(
    parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
    parameter int         ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              bit_valid,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    state_t     state, state_next;
    op_t        op, op_next;
    logic       armed;
    logic [7:0] tx;
    logic       rdata_pend;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       addr_load;
    logic       addr_inc;
    logic       we_set;
    logic       re_set;
    logic       err_set;

    spi_byte_rx u_byte_rx (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .bit_valid (bit_valid),
        .mosi      (mosi),
        .rx_byte   (rx_byte),
        .byte_done (byte_done)
    );

    // State, operation and re-arm flag; after a reset a new transaction needs cs_n to go high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op    <= OP_RD;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            op    <= op_next;
            if (cs_n) begin
                armed <= 1'b1;
            end
        end
    end

    // Next-state decode and the single-cycle requests that the datapath registers.
    always_comb begin
        state_next = state;
        op_next    = op;
        addr_load  = 1'b0;
        addr_inc   = 1'b0;
        we_set     = 1'b0;
        re_set     = 1'b0;
        err_set    = 1'b0;
        if (cs_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state_next = CMD;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_READ) begin
                            op_next    = OP_RD;
                            state_next = ADDR;
                        end else if (rx_byte == CMD_WRITE) begin
                            op_next    = OP_WR;
                            state_next = ADDR;
                        end else begin
                            err_set    = 1'b1;
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        addr_load = 1'b1;
                        if (op == OP_WR) begin
                            state_next = WDATA;
                        end else begin
                            re_set     = 1'b1;
                            state_next = RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (byte_done) begin
                        we_set = 1'b1;
                    end
                end
                RDATA: begin
                    if (byte_done) begin
                        addr_inc = 1'b1;
                        re_set   = 1'b1;
                    end
                end
                IGNORE: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Strobes, address counter, write data and the read shifter; writes advance the address the cycle after mem_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            cmd_err    <= 1'b0;
            rdata_pend <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tx         <= '0;
        end else begin
            mem_we     <= we_set;
            mem_re     <= re_set;
            cmd_err    <= err_set;
            rdata_pend <= mem_re;
            if (we_set) begin
                mem_wdata <= rx_byte;
            end
            if (addr_load) begin
                mem_addr <= ADDR_W'(rx_byte);
            end else if (addr_inc || mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (cs_n) begin
                tx <= '0;
            end else if (state == RDATA && rdata_pend) begin
                tx <= mem_rdata;
            end else if (state == RDATA && bit_valid) begin
                tx <= {tx[6:0], 1'b0};
            end
        end
    end

    assign miso    = (state == RDATA) && tx[7];
    assign miso_oe = (state == RDATA);
    assign busy    = !cs_n && (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with a small registered memory model.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       bit_valid;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;
    logic       cmd_err;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    int         we_cnt = 0;
    int         re_cnt = 0;
    int         err_rises = 0;
    int         err_cycles = 0;
    int         both_cnt = 0;
    logic       err_prev = 1'b0;
    logic [7:0] we_addr_log [64];
    logic [7:0] we_data_log [64];
    logic [7:0] re_addr_log [64];
    logic       last_miso;

    int we_base;
    int re_base;
    int err_base;
    int errcyc_base;

    spi_cmd_ctrl #(
        .ADDR_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .bit_valid (bit_valid),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    // Strobe monitor sampling just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_we) begin
            if (we_cnt < 64) begin
                we_addr_log[we_cnt] = mem_addr;
                we_data_log[we_cnt] = mem_wdata;
            end
            we_cnt++;
        end
        if (mem_re) begin
            if (re_cnt < 64) begin
                re_addr_log[re_cnt] = mem_addr;
            end
            re_cnt++;
        end
        if (mem_we && mem_re) begin
            both_cnt++;
        end
        if (cmd_err) begin
            err_cycles++;
            if (!err_prev) begin
                err_rises++;
            end
        end
        err_prev = cmd_err;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        last_miso = miso;
        mosi      = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        mosi      = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic read_byte_check(input string tag, input logic [7:0] exp);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b0);
            check_output(tag, {31'd0, last_miso}, {31'd0, exp[i]});
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic snapshot();
        we_base     = we_cnt;
        re_base     = re_cnt;
        err_base    = err_rises;
        errcyc_base = err_cycles;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
        end
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'h81;
        mem[8'h60] = 8'hF0;

        rst       = 1'b1;
        cs_n      = 1'b1;
        bit_valid = 1'b0;
        mosi      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_output("reset_miso", {31'd0, miso}, 32'd0);
        check_output("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check_output("reset_addr", {24'd0, mem_addr}, 32'd0);
        check_output("reset_wdata", {24'd0, mem_wdata}, 32'd0);
        check_output("reset_we", {31'd0, mem_we}, 32'd0);
        check_output("reset_re", {31'd0, mem_re}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_cmd_err", {31'd0, cmd_err}, 32'd0);

        // Burst write of two bytes starting at 0x10.
        snapshot();
        cs_low();
        check_output("wr_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'hA5);
        send_byte(8'h5A);
        check_output("wr_miso_oe", {31'd0, miso_oe}, 32'd0);
        cs_high();
        check_output("wr_count", we_cnt - we_base, 32'd2);
        check_output("wr0_addr", {24'd0, we_addr_log[we_base]}, 32'h10);
        check_output("wr0_data", {24'd0, we_data_log[we_base]}, 32'hA5);
        check_output("wr1_addr", {24'd0, we_addr_log[we_base + 1]}, 32'h11);
        check_output("wr1_data", {24'd0, we_data_log[we_base + 1]}, 32'h5A);
        check_output("wr_no_read", re_cnt - re_base, 32'd0);
        check_output("wr_no_err", err_rises - err_base, 32'd0);
        check_output("wr_busy_after", {31'd0, busy}, 32'd0);

        // Burst read of two bytes from 0x20.
        snapshot();
        cs_low();
        send_byte(8'h03);
        send_byte(8'h20);
        check_output("rd_miso_oe", {31'd0, miso_oe}, 32'd1);
        read_byte_check("rd_byte0_bit", 8'h3C);
        read_byte_check("rd_byte1_bit", 8'h81);
        cs_high();
        check_output("rd_count", re_cnt - re_base, 32'd3);
        check_output("rd0_addr", {24'd0, re_addr_log[re_base]}, 32'h20);
        check_output("rd1_addr", {24'd0, re_addr_log[re_base + 1]}, 32'h21);
        check_output("rd2_addr", {24'd0, re_addr_log[re_base + 2]}, 32'h22);
        check_output("rd_no_write", we_cnt - we_base, 32'd0);
        check_output("rd_miso_oe_after", {31'd0, miso_oe}, 32'd0);
        check_output("rd_miso_after", {31'd0, miso}, 32'd0);

        // Unknown command, followed by bytes that must be ignored.
        snapshot();
        cs_low();
        send_byte(8'h9F);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h33);
        check_output("bad_busy", {31'd0, busy}, 32'd1);
        cs_high();
        check_output("bad_err_pulses", err_rises - err_base, 32'd1);
        check_output("bad_err_width", err_cycles - errcyc_base, 32'd1);
        check_output("bad_no_write", we_cnt - we_base, 32'd0);
        check_output("bad_no_read", re_cnt - re_base, 32'd0);
        check_output("bad_busy_after", {31'd0, busy}, 32'd0);

        // Abort mid data byte, then a clean write.
        snapshot();
        cs_low();
        send_byte(8'h02);
        send_byte(8'h40);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
        end
        cs_high();
        check_output("abort_no_write", we_cnt - we_base, 32'd0);
        check_output("abort_idle", {31'd0, busy}, 32'd0);
        cs_low();
        send_byte(8'h02);
        send_byte(8'h41);
        send_byte(8'h77);
        cs_high();
        check_output("abort_retry_count", we_cnt - we_base, 32'd1);
        check_output("abort_retry_addr", {24'd0, we_addr_log[we_base]}, 32'h41);
        check_output("abort_retry_data", {24'd0, we_data_log[we_base]}, 32'h77);

        // Address wrap from 0xFF to 0x00.
        snapshot();
        cs_low();
        send_byte(8'h02);
        send_byte(8'hFF);
        send_byte(8'h11);
        send_byte(8'h22);
        check_output("wrap_addr_after", {24'd0, mem_addr}, 32'h01);
        cs_high();
        check_output("wrap_count", we_cnt - we_base, 32'd2);
        check_output("wrap0_addr", {24'd0, we_addr_log[we_base]}, 32'hFF);
        check_output("wrap0_data", {24'd0, we_data_log[we_base]}, 32'h11);
        check_output("wrap1_addr", {24'd0, we_addr_log[we_base + 1]}, 32'h00);
        check_output("wrap1_data", {24'd0, we_data_log[we_base + 1]}, 32'h22);

        // cs_n rising together with the 8th data bit drops that byte.
        snapshot();
        cs_low();
        send_byte(8'h02);
        send_byte(8'h30);
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1);
        end
        @(negedge clk);
        mosi      = 1'b1;
        bit_valid = 1'b1;
        cs_n      = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        mosi      = 1'b0;
        repeat (4) @(negedge clk);
        check_output("edge_no_write", we_cnt - we_base, 32'd0);
        check_output("edge_no_read", re_cnt - re_base, 32'd0);
        cs_low();
        send_byte(8'h02);
        send_byte(8'h50);
        send_byte(8'h66);
        cs_high();
        check_output("edge_next_count", we_cnt - we_base, 32'd1);
        check_output("edge_next_addr", {24'd0, we_addr_log[we_base]}, 32'h50);
        check_output("edge_next_data", {24'd0, we_data_log[we_base]}, 32'h66);
        check_output("no_we_re_overlap", both_cnt, 32'd0);

        // Reset asserted during the third read bit.
        cs_low();
        send_byte(8'h03);
        send_byte(8'h60);
        send_bit(1'b0);
        check_output("rst_rd_bit0", {31'd0, last_miso}, 32'd1);
        send_bit(1'b0);
        check_output("rst_rd_bit1", {31'd0, last_miso}, 32'd1);
        @(negedge clk);
        mosi      = 1'b0;
        bit_valid = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        rst       = 1'b0;
        check_output("rst_miso", {31'd0, miso}, 32'd0);
        check_output("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check_output("rst_addr", {24'd0, mem_addr}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        snapshot();
        send_byte(8'h03);
        send_byte(8'h20);
        check_output("rst_no_read", re_cnt - re_base, 32'd0);
        check_output("rst_no_write", we_cnt - we_base, 32'd0);
        check_output("rst_stays_idle", {31'd0, busy}, 32'd0);
        cs_high();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
